layer_load_sequencer: RTL and testbench

Hardware replacement for host-driven scratchpad loading around `top`. It accepts a valid/ready word stream from the host and, for each of up to `NUM_CH` channels, writes kernel words and then ifmap words into `top`'s scratchpads. It then raises route-enable, waits for the core's done, and pulses register-clear between channels. Ofmap results are captured into an internal FIFO with valid/ready egress and a sticky overflow flag. The block sits between the host/DMA interface and `top`.

---
 rtl/layer_load_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_layer_load_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_load_sequencer.sv
`timescale 1ns/1ps
// Streams kernel then ifmap words into the core scratchpads for each channel,
// sequences route/clear handshakes with the core and buffers ofmap results.
module layer_load_sequencer #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_CH          = 4,
  parameter int OFIFO_DEPTH     = 8,
  localparam int NCW = $clog2(NUM_CH + 1),
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OW  = 2 * DATA_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [NCW-1:0]             i_num_ch,
  input  logic [ADDR_WIDTH-1:0]      i_w_words,
  input  logic [ADDR_WIDTH-1:0]      i_i_words,
  input  logic [SRAM_DATA_WIDTH-1:0] i_s_data,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  output logic [SRAM_DATA_WIDTH-1:0] o_data_in,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic                       o_spad_select,
  output logic                       o_write_en,
  output logic [ADDR_WIDTH-1:0]      o_i_addr_end,
  output logic                       o_route_en,
  output logic                       o_reg_clear,
  input  logic                       i_core_done,
  input  logic [OW-1:0]              i_ofmap,
  input  logic                       i_ofmap_valid,
  output logic [OW-1:0]              o_m_data,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic [CHW-1:0]             o_ch_idx,
  output logic                       o_busy,
  output logic                       o_overflow,
  output logic                       o_err,
  output logic                       o_done
);

  localparam int PW = $clog2(OFIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(OFIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_I, S_GAP, S_ROUTE, S_CLEAR, S_DRAIN, S_DONE
  } state_t;

  state_t                     state_q;
  logic [NCW-1:0]             num_ch_q;
  logic [ADDR_WIDTH-1:0]      w_words_q, i_words_q, word_cnt_q, i_addr_end_q;
  logic [CHW-1:0]             ch_idx_q;
  logic                       gap_cnt_q;
  logic                       we_q, sel_q, route_q, clear_q, err_q, done_q;
  logic [SRAM_DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0]      addr_q;

  logic [OW-1:0]              fifo_mem [OFIFO_DEPTH];
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [PW:0]                fifo_cnt_q, fifo_cnt_d;
  logic                       overflow_q;

  logic                  load_st, xfer, last_word, cfg_bad, start_ok, more_ch;
  logic                  full, pop, push_ok;
  logic [ADDR_WIDTH-1:0] words_cur;

  assign load_st   = (state_q == S_LOAD_W) || (state_q == S_LOAD_I);
  assign xfer      = load_st & i_s_valid;
  assign words_cur = (state_q == S_LOAD_I) ? i_words_q : w_words_q;
  assign last_word = (word_cnt_q == words_cur - ADDR_WIDTH'(1));
  assign cfg_bad   = (i_num_ch == '0) || (i_num_ch > NCW'(NUM_CH)) ||
                     (i_w_words == '0) || (i_i_words == '0);
  assign start_ok  = (state_q == S_IDLE) & i_start & ~cfg_bad;
  assign more_ch   = (NCW'(ch_idx_q) + NCW'(1)) < num_ch_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      num_ch_q     <= '0;
      w_words_q    <= '0;
      i_words_q    <= '0;
      word_cnt_q   <= '0;
      i_addr_end_q <= '0;
      ch_idx_q     <= '0;
      gap_cnt_q    <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      route_q      <= 1'b0;
      clear_q      <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Write strobe and pulses default low; the write bus is zeroed when idle.
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      clear_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              num_ch_q     <= i_num_ch;
              w_words_q    <= i_w_words;
              i_words_q    <= i_i_words;
              i_addr_end_q <= i_i_words - ADDR_WIDTH'(1);
              ch_idx_q     <= '0;
              word_cnt_q   <= '0;
              state_q      <= S_LOAD_W;
            end
          end
        end
        S_LOAD_W, S_LOAD_I: begin
          if (xfer) begin
            we_q   <= 1'b1;
            data_q <= i_s_data;
            addr_q <= word_cnt_q;
            sel_q  <= (state_q == S_LOAD_I);
            if (last_word) begin
              word_cnt_q <= '0;
              if (state_q == S_LOAD_W) begin
                state_q <= S_LOAD_I;
              end else begin
                gap_cnt_q <= 1'b0;
                state_q   <= S_GAP;
              end
            end else begin
              word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q) begin
            route_q <= 1'b1;
            state_q <= S_ROUTE;
          end else begin
            gap_cnt_q <= 1'b1;
          end
        end
        S_ROUTE: begin
          if (i_core_done) begin
            route_q <= 1'b0;
            clear_q <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (more_ch) begin
            ch_idx_q <= ch_idx_q + CHW'(1);
            state_q  <= S_LOAD_W;
          end else begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ofmap FIFO: a push into a full FIFO is still accepted when the head leaves the same cycle.
  assign full    = (fifo_cnt_q == FULL_CNT);
  assign pop     = (fifo_cnt_q != '0) & i_m_ready;
  assign push_ok = i_ofmap_valid & (~full | pop);

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (PW+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (PW+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= i_ofmap;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_d;
      if (start_ok) overflow_q <= 1'b0;
      if (i_ofmap_valid & full & ~pop) overflow_q <= 1'b1;
    end
  end

  assign o_s_ready     = load_st;
  assign o_data_in     = data_q;
  assign o_write_addr  = addr_q;
  assign o_spad_select = sel_q;
  assign o_write_en    = we_q;
  assign o_i_addr_end  = i_addr_end_q;
  assign o_route_en    = route_q;
  assign o_reg_clear   = clear_q;
  assign o_m_valid     = (fifo_cnt_q != '0);
  assign o_m_data      = o_m_valid ? fifo_mem[rd_ptr_q] : '0;
  assign o_ch_idx      = ch_idx_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_overflow    = overflow_q;
  assign o_err         = err_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_layer_load_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for layer_load_sequencer: directed runs, FIFO overflow and
// simultaneous push/pop, config errors and reset during ROUTE.
module tb_layer_load_sequencer;
  localparam int SDW = 64, AW = 8, DW = 8, NCH = 4, DEPTH = 8;
  localparam int NCW = 3, CHW = 2, OW = 16;

  logic           i_clk = 1'b0;
  logic           i_rst, i_start, i_s_valid, i_core_done, i_ofmap_valid, i_m_ready;
  logic [NCW-1:0] i_num_ch;
  logic [AW-1:0]  i_w_words, i_i_words;
  logic [SDW-1:0] i_s_data;
  logic [OW-1:0]  i_ofmap;
  logic           o_s_ready, o_spad_select, o_write_en, o_route_en, o_reg_clear;
  logic           o_m_valid, o_busy, o_overflow, o_err, o_done;
  logic [SDW-1:0] o_data_in;
  logic [AW-1:0]  o_write_addr, o_i_addr_end;
  logic [OW-1:0]  o_m_data;
  logic [CHW-1:0] o_ch_idx;

  always #5 i_clk = ~i_clk;

  layer_load_sequencer #(
    .SRAM_DATA_WIDTH(SDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_CH(NCH), .OFIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_ch(i_num_ch),
    .i_w_words(i_w_words), .i_i_words(i_i_words), .i_s_data(i_s_data),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .o_data_in(o_data_in),
    .o_write_addr(o_write_addr), .o_spad_select(o_spad_select),
    .o_write_en(o_write_en), .o_i_addr_end(o_i_addr_end), .o_route_en(o_route_en),
    .o_reg_clear(o_reg_clear), .i_core_done(i_core_done), .i_ofmap(i_ofmap),
    .i_ofmap_valid(i_ofmap_valid), .o_m_data(o_m_data), .o_m_valid(o_m_valid),
    .i_m_ready(i_m_ready), .o_ch_idx(o_ch_idx), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_err(o_err), .o_done(o_done)
  );

  typedef struct {
    logic           sel;
    logic [AW-1:0]  addr;
    logic [SDW-1:0] data;
    logic [CHW-1:0] ch;
  } wr_t;

  wr_t           wq[$];
  logic [OW-1:0] mq[$];
  wr_t           mon_w;
  logic [OW-1:0] mon_m;
  int            checks = 0, errors = 0;
  int            done_cnt = 0, clr_cnt = 0, err_cnt = 0;
  time           last_hs_t = 0;
  logic          prev_route = 1'b0, prev_core_done = 1'b0;
  logic [AW-1:0] exp_iend = '0;
  bit            core_auto = 1'b1;
  int            route_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_data"}, o_data_in, 64'h0);
    chk(name, {o_s_ready, o_write_en, o_write_addr, o_spad_select, o_i_addr_end,
               o_route_en, o_reg_clear, o_m_data, o_m_valid, o_ch_idx, o_busy,
               o_overflow, o_err, o_done}, 64'h0);
  endtask

  // Monitor: compares every scratchpad write and every egress pop against the queues.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_write_en) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got write addr 0x%0h sel %0d, want none", o_write_addr, o_spad_select);
        end else begin
          mon_w = wq.pop_front();
          $display("write ch=%0d sel=%0d addr=%0d data=%h", o_ch_idx, o_spad_select, o_write_addr, o_data_in);
          chk("wr_sel", o_spad_select, mon_w.sel);
          chk("wr_addr", o_write_addr, mon_w.addr);
          chk("wr_data", o_data_in, mon_w.data);
          chk("wr_ch_idx", o_ch_idx, mon_w.ch);
          if (mon_w.sel) chk("i_addr_end", o_i_addr_end, exp_iend);
        end
      end
      if (o_m_valid && i_m_ready) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_egress: got 0x%0h, want none", o_m_data);
        end else begin
          mon_m = mq.pop_front();
          $display("egress data=%h", o_m_data);
          chk("egress_data", o_m_data, mon_m);
        end
      end
      if (o_route_en && !prev_route) chk("route_latency_ns", $time - last_hs_t, 30);
      if (o_reg_clear) begin
        clr_cnt++;
        chk("clear_after_core_done", {prev_core_done, o_route_en}, 2'b10);
      end
      if (o_done) begin
        done_cnt++;
        chk("done_fifo_empty", o_m_valid, 1'b0);
      end
      if (o_err) err_cnt++;
    end
    prev_route     = o_route_en;
    prev_core_done = i_core_done;
  end

  // Core model: answers route-enable with a one-cycle done after three cycles.
  initial begin
    i_core_done = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_core_done = 1'b0;
      if (core_auto && o_route_en) begin
        route_cyc++;
        if (route_cyc == 3) begin
          i_core_done = 1'b1;
          route_cyc = 0;
        end
      end else begin
        route_cyc = 0;
      end
    end
  end

  task automatic stream(input int nch, input int w, input int iw, input bit toggle,
                        input bit poke, input logic [63:0] base);
    int  k, b, pos, total;
    bit  poked;
    wr_t e;
    total = nch * (w + iw);
    exp_iend = AW'(iw - 1);
    i_num_ch = NCW'(nch); i_w_words = AW'(w); i_i_words = AW'(iw);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    k = 0; b = 0; poked = 1'b0;
    while (k < total && b < 3000) begin
      pos = k % (w + iw);
      i_s_valid = toggle ? ((b % 2) == 0) : 1'b1;
      i_s_data  = base + 64'(k);
      if (poke && !poked && k == w) begin
        // start pulse with a different config while loading ifmap: must be ignored
        poked = 1'b1;
        i_start = 1'b1; i_num_ch = 3'd2; i_w_words = 8'd5; i_i_words = 8'd7;
      end
      @(negedge i_clk);
      if (b == 0) begin
        chk("busy_after_start", o_busy, 1'b1);
        chk("ovf_clear_on_start", o_overflow, 1'b0);
      end
      if (i_s_valid && o_s_ready) begin
        e.sel  = (pos >= w);
        e.addr = AW'((pos >= w) ? pos - w : pos);
        e.data = i_s_data;
        e.ch   = CHW'(k / (w + iw));
        wq.push_back(e);
        if (pos == w + iw - 1) last_hs_t = $time;
        k++;
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      b++;
    end
    i_s_valid = 1'b0;
    chk("stream_complete", k, total);
  endtask

  task automatic run(input int nch, input int w, input int iw, input bit toggle,
                     input bit poke, input bit hold_ready, input logic [63:0] base);
    int clr0, done0, err0, b;
    clr0 = clr_cnt; done0 = done_cnt; err0 = err_cnt;
    stream(nch, w, iw, toggle, poke, base);
    if (hold_ready) begin
      repeat (20) @(posedge i_clk);
      #1;
      chk("drain_waits_for_fifo", done_cnt - done0, 0);
      chk("fifo_still_holding", o_m_valid, 1'b1);
      i_m_ready = 1'b1;
    end
    b = 0;
    while (done_cnt == done0 && b < 500) begin
      @(posedge i_clk); #1;
      b++;
    end
    chk("done_pulse", done_cnt - done0, 1);
    chk("clear_pulses", clr_cnt - clr0, nch);
    chk("no_err_in_run", err_cnt - err0, 0);
    chk("all_writes_seen", wq.size(), 0);
    chk("idle_after_done", o_busy, 1'b0);
  endtask

  task automatic push_ofmap(input logic [OW-1:0] v, input logic rdy);
    i_ofmap_valid = 1'b1; i_ofmap = v; i_m_ready = rdy;
    if (mq.size() < DEPTH || (mq.size() > 0 && rdy)) mq.push_back(v);
    @(posedge i_clk); #1;
    i_ofmap_valid = 1'b0;
  endtask

  task automatic cfg_err(input int nch, input int w, input int iw);
    i_num_ch = NCW'(nch); i_w_words = AW'(w); i_i_words = AW'(iw);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(negedge i_clk);
    chk("err_pulse", o_err, 1'b1);
    chk("err_stays_idle", o_busy, 1'b0);
    @(negedge i_clk);
    chk("err_one_cycle", o_err, 1'b0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int b;
    i_rst = 1'b1; i_start = 1'b0; i_s_valid = 1'b0; i_s_data = '0;
    i_num_ch = '0; i_w_words = '0; i_i_words = '0;
    i_ofmap = '0; i_ofmap_valid = 1'b0; i_m_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_zero("reset_outputs");
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    run(1, 2, 3, 1'b0, 1'b1, 1'b0, 64'h1111_0000_0000_0000);
    run(3, 1, 2, 1'b1, 1'b0, 1'b0, 64'h2222_0000_0000_0000);

    for (int v = 1; v <= 10; v++) push_ofmap(OW'(v), 1'b0);
    chk("overflow_set", o_overflow, 1'b1);
    chk("fifo_head_first", o_m_data, 16'h0001);
    run(1, 1, 1, 1'b0, 1'b0, 1'b1, 64'h3333_0000_0000_0000);
    chk("egress_all_seen", mq.size(), 0);

    i_m_ready = 1'b0;
    for (int v = 0; v < 8; v++) push_ofmap(16'h0100 + OW'(v), 1'b0);
    push_ofmap(16'h0108, 1'b1);
    i_m_ready = 1'b0;
    @(posedge i_clk); #1;
    chk("full_push_pop_no_ovf", o_overflow, 1'b0);
    chk("full_push_pop_head", o_m_data, 16'h0101);
    i_m_ready = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    chk("full_push_pop_drained", mq.size(), 0);
    chk("fifo_empty_after_drain", o_m_valid, 1'b0);

    cfg_err(0, 2, 2);
    cfg_err(5, 2, 2);
    cfg_err(1, 0, 2);
    cfg_err(1, 2, 0);

    core_auto = 1'b0;
    stream(1, 1, 1, 1'b0, 1'b0, 64'h4444_0000_0000_0000);
    b = 0;
    while (!o_route_en && b < 50) begin
      @(posedge i_clk); #1;
      b++;
    end
    chk("reached_route", o_route_en, 1'b1);
    repeat (2) @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    chk_zero("reset_in_route");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    core_auto = 1'b1;
    run(1, 1, 2, 1'b0, 1'b0, 1'b0, 64'h5555_0000_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
